// File: rtl/vga_timing_gen.sv
// ---------------------------------------------------------------------------
// vga_timing_gen
//
// Purpose: generates the raster timing for a VGA style display. The system
// clock is divided down to a pixel rate. Column (x) and line (y) counters
// run from that rate, and sync / active-video levels are decoded from the
// counters. The count enable freezes the whole timing chain in place.
//
// Optional feature: define VGA_TIMING_FRAME_CNT_EN to add a 16-bit frame
// counter output (frame_cnt). In the default build that port is absent.
//
// Ports:
//   clk        in   system clock, all logic on the rising edge
//   reset      in   asynchronous active-low reset
//   en         in   count enable; low holds the divider and the counters
//   h_sync     out  horizontal sync, asserted level set by H_SYNC_POL
//   v_sync     out  vertical sync, asserted level set by V_SYNC_POL
//   x, y       out  current pixel column / line (RES_BITS each)
//   video_on   out  high inside the active area
//   pixel_tick out  one-clock strobe on each pixel advance
//   line_end   out  one-clock strobe on the last pixel of a line
//   frame_end  out  one-clock strobe on the last pixel of a frame
//   frame_cnt  out  completed-frame count (only with VGA_TIMING_FRAME_CNT_EN)
//
// H_TOTAL and V_TOTAL must both be less than 2**RES_BITS.
// ---------------------------------------------------------------------------
module vga_timing_gen #(
  parameter int RES_BITS   = 10,
  parameter int CLK_DIV    = 4,
  parameter int H_ACTIVE   = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_ACTIVE   = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter int H_SYNC_POL = 0,
  parameter int V_SYNC_POL = 0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                en,
  output logic                h_sync,
  output logic                v_sync,
  output logic [RES_BITS-1:0] x,
  output logic [RES_BITS-1:0] y,
  output logic                video_on,
  output logic                pixel_tick,
  output logic                line_end,
`ifdef VGA_TIMING_FRAME_CNT_EN
  output logic                frame_end,
  output logic [15:0]         frame_cnt
`else
  output logic                frame_end
`endif
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [RES_BITS-1:0] H_LAST    = RES_BITS'(H_TOTAL - 1);
  localparam logic [RES_BITS-1:0] V_LAST    = RES_BITS'(V_TOTAL - 1);
  localparam logic [RES_BITS-1:0] H_ACT     = RES_BITS'(H_ACTIVE);
  localparam logic [RES_BITS-1:0] V_ACT     = RES_BITS'(V_ACTIVE);
  localparam logic [RES_BITS-1:0] H_SYNC_LO = RES_BITS'(H_ACTIVE + H_FP);
  localparam logic [RES_BITS-1:0] H_SYNC_HI = RES_BITS'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [RES_BITS-1:0] V_SYNC_LO = RES_BITS'(V_ACTIVE + V_FP);
  localparam logic [RES_BITS-1:0] V_SYNC_HI = RES_BITS'(V_ACTIVE + V_FP + V_SYNC);

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);
  localparam logic       H_POL    = (H_SYNC_POL != 0);
  localparam logic       V_POL    = (V_SYNC_POL != 0);

  logic [7:0]          r_div;
  logic [RES_BITS-1:0] r_x;
  logic [RES_BITS-1:0] r_y;
  logic                r_h_sync;
  logic                r_v_sync;
  logic                r_video_on;

  logic                w_tick;
  logic                w_line_end;
  logic                w_frame_end;
  logic [7:0]          w_div_nxt;
  logic [RES_BITS-1:0] w_x_nxt;
  logic [RES_BITS-1:0] w_y_nxt;

  function automatic logic f_in_window(input logic [RES_BITS-1:0] v,
                                       input logic [RES_BITS-1:0] lo,
                                       input logic [RES_BITS-1:0] hi);
    return (v >= lo) && (v < hi);
  endfunction

  // Strobes are gated by reset so they stay low while reset is held, even
  // though en may be high; with CLK_DIV=1 the divider sits at 0 and the
  // tick simply follows en.
  assign w_tick      = reset & en & (r_div == DIV_LAST);
  assign w_line_end  = w_tick & (r_x == H_LAST);
  assign w_frame_end = w_line_end & (r_y == V_LAST);

  assign w_div_nxt = (r_div == DIV_LAST) ? 8'd0 : r_div + 8'd1;

  always_comb begin
    w_x_nxt = r_x;
    w_y_nxt = r_y;
    if (w_tick) begin
      w_x_nxt = (r_x == H_LAST) ? '0 : r_x + 1'b1;
    end
    if (w_line_end) begin
      w_y_nxt = (r_y == V_LAST) ? '0 : r_y + 1'b1;
    end
  end

  // Sync and video levels are decoded from the next counter values and
  // registered alongside the counters, so they change on the same edge as
  // x/y and never glitch.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_div      <= 8'd0;
      r_x        <= '0;
      r_y        <= '0;
      r_h_sync   <= ~H_POL;
      r_v_sync   <= ~V_POL;
      r_video_on <= 1'b1;
    end else begin
      if (en) begin
        r_div <= w_div_nxt;
      end
      r_x        <= w_x_nxt;
      r_y        <= w_y_nxt;
      r_h_sync   <= f_in_window(w_x_nxt, H_SYNC_LO, H_SYNC_HI) ? H_POL : ~H_POL;
      r_v_sync   <= f_in_window(w_y_nxt, V_SYNC_LO, V_SYNC_HI) ? V_POL : ~V_POL;
      r_video_on <= (w_x_nxt < H_ACT) && (w_y_nxt < V_ACT);
    end
  end

`ifdef VGA_TIMING_FRAME_CNT_EN
  logic [15:0] r_frame_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_frame_cnt <= 16'd0;
    end else if (w_frame_end) begin
      r_frame_cnt <= r_frame_cnt + 16'd1;
    end
  end

  assign frame_cnt = r_frame_cnt;
`endif

  assign x          = r_x;
  assign y          = r_y;
  assign h_sync     = r_h_sync;
  assign v_sync     = r_v_sync;
  assign video_on   = r_video_on;
  assign pixel_tick = w_tick;
  assign line_end   = w_line_end;
  assign frame_end  = w_frame_end;

endmodule

// File: tb/tb_vga_timing_gen.sv
// ---------------------------------------------------------------------------
// tb_vga_timing_gen
//
// Two instances on a reduced raster (14 x 8 pixels):
//   dut_a: CLK_DIV=3, active-low syncs
//   dut_b: CLK_DIV=1, active-high syncs
// Each drive cycle pushes the expected outputs of both instances into a
// scoreboard queue; a monitor pops and compares them on the falling edge.
// Scenario tasks add their own direct checks.
// ---------------------------------------------------------------------------
module tb_vga_timing_gen;

  localparam int HA = 8, HF = 2, HS = 3, HB = 1;
  localparam int VA = 4, VF = 1, VS = 2, VB = 1;
  localparam int HT = HA + HF + HS + HB;  // 14
  localparam int VT = VA + VF + VS + VB;  // 8
  localparam int DA = 3;
  localparam int DB = 1;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic en = 1'b0;

  logic       a_hs, a_vs, a_vo, a_pt, a_le, a_fe;
  logic [9:0] a_x, a_y;
  logic       b_hs, b_vs, b_vo, b_pt, b_le, b_fe;
  logic [9:0] b_x, b_y;
`ifdef VGA_TIMING_FRAME_CNT_EN
  logic [15:0] a_fc, b_fc;
`endif

  always #5 clk = ~clk;

  vga_timing_gen #(
    .RES_BITS(10), .CLK_DIV(DA),
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .H_SYNC_POL(0), .V_SYNC_POL(0)
  ) dut_a (
    .clk(clk), .reset(reset), .en(en),
    .h_sync(a_hs), .v_sync(a_vs), .x(a_x), .y(a_y), .video_on(a_vo),
    .pixel_tick(a_pt), .line_end(a_le),
`ifdef VGA_TIMING_FRAME_CNT_EN
    .frame_end(a_fe), .frame_cnt(a_fc)
`else
    .frame_end(a_fe)
`endif
  );

  vga_timing_gen #(
    .RES_BITS(10), .CLK_DIV(DB),
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .H_SYNC_POL(1), .V_SYNC_POL(1)
  ) dut_b (
    .clk(clk), .reset(reset), .en(en),
    .h_sync(b_hs), .v_sync(b_vs), .x(b_x), .y(b_y), .video_on(b_vo),
    .pixel_tick(b_pt), .line_end(b_le),
`ifdef VGA_TIMING_FRAME_CNT_EN
    .frame_end(b_fe), .frame_cnt(b_fc)
`else
    .frame_end(b_fe)
`endif
  );

  typedef struct {
    int div;
    int x;
    int y;
  } st_t;

  typedef struct {
    int   x;
    int   y;
    logic hs, vs, vo, pt, le, fe;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  st_t  sa, sb;
  int   checks = 0;
  int   errors = 0;

  function automatic exp_t mk_exp(input st_t s, input int d, input logic pol,
                                  input logic e, input logic r);
    exp_t o;
    o.x  = s.x;
    o.y  = s.y;
    o.pt = e && r && (s.div == d - 1);
    o.le = o.pt && (s.x == HT - 1);
    o.fe = o.le && (s.y == VT - 1);
    o.hs = (s.x >= HA + HF && s.x < HA + HF + HS) ? pol : !pol;
    o.vs = (s.y >= VA + VF && s.y < VA + VF + VS) ? pol : !pol;
    o.vo = (s.x < HA) && (s.y < VA);
    return o;
  endfunction

  function automatic st_t adv(input st_t s, input int d, input logic e,
                              input logic r);
    st_t n;
    logic tick;
    n = s;
    if (!r) begin
      n = '{0, 0, 0};
    end else if (e) begin
      tick  = (s.div == d - 1);
      n.div = tick ? 0 : s.div + 1;
      if (tick) begin
        if (s.x == HT - 1) begin
          n.x = 0;
          n.y = (s.y == VT - 1) ? 0 : s.y + 1;
        end else begin
          n.x = s.x + 1;
        end
      end
    end
    return n;
  endfunction

  // Called one time unit after a rising edge; drives one clock of stimulus.
  task automatic drive(input logic e, input logic r);
    en    = e;
    reset = r;
    if (!r) begin
      sa = '{0, 0, 0};
      sb = '{0, 0, 0};
    end
    qa.push_back(mk_exp(sa, DA, 1'b0, e, r));
    qb.push_back(mk_exp(sb, DB, 1'b1, e, r));
    @(posedge clk);
    sa = adv(sa, DA, e, r);
    sb = adv(sb, DB, e, r);
    #1;
  endtask

  // Scoreboard monitor.
  always @(negedge clk) begin
    exp_t ea, eb;
    if (qa.size() > 0) begin
      ea = qa.pop_front();
      checks++;
      if (a_x !== 10'(ea.x) || a_y !== 10'(ea.y)) begin
        errors++;
        $display("FAIL sb_a_xy at %0t: got x=%0d y=%0d, want x=%0d y=%0d",
                 $time, a_x, a_y, ea.x, ea.y);
      end
      checks++;
      if ({a_hs, a_vs, a_vo, a_pt, a_le, a_fe} !==
          {ea.hs, ea.vs, ea.vo, ea.pt, ea.le, ea.fe}) begin
        errors++;
        $display("FAIL sb_a_flags at %0t (x=%0d y=%0d): got hs,vs,vo,pt,le,fe=%b, want %b",
                 $time, ea.x, ea.y, {a_hs, a_vs, a_vo, a_pt, a_le, a_fe},
                 {ea.hs, ea.vs, ea.vo, ea.pt, ea.le, ea.fe});
      end
    end
    if (qb.size() > 0) begin
      eb = qb.pop_front();
      checks++;
      if (b_x !== 10'(eb.x) || b_y !== 10'(eb.y)) begin
        errors++;
        $display("FAIL sb_b_xy at %0t: got x=%0d y=%0d, want x=%0d y=%0d",
                 $time, b_x, b_y, eb.x, eb.y);
      end
      checks++;
      if ({b_hs, b_vs, b_vo, b_pt, b_le, b_fe} !==
          {eb.hs, eb.vs, eb.vo, eb.pt, eb.le, eb.fe}) begin
        errors++;
        $display("FAIL sb_b_flags at %0t (x=%0d y=%0d): got hs,vs,vo,pt,le,fe=%b, want %b",
                 $time, eb.x, eb.y, {b_hs, b_vs, b_vo, b_pt, b_le, b_fe},
                 {eb.hs, eb.vs, eb.vo, eb.pt, eb.le, eb.fe});
      end
    end
  end

  task automatic test_reset();
    en = 1'b1;  // strobes must stay low while reset is held
    #1;
    checks++;
    if ({a_x, a_y} !== 20'd0 || {b_x, b_y} !== 20'd0) begin
      errors++;
      $display("FAIL reset_xy: got a=%0d,%0d b=%0d,%0d, want 0,0", a_x, a_y, b_x, b_y);
    end
    checks++;
    if ({a_hs, a_vs, a_vo} !== 3'b111 || {b_hs, b_vs, b_vo} !== 3'b001) begin
      errors++;
      $display("FAIL reset_levels: got a=%b b=%b, want a=111 b=001",
               {a_hs, a_vs, a_vo}, {b_hs, b_vs, b_vo});
    end
    checks++;
    if ({a_pt, a_le, a_fe, b_pt, b_le, b_fe} !== 6'b0) begin
      errors++;
      $display("FAIL reset_strobes: got %b, want 000000",
               {a_pt, a_le, a_fe, b_pt, b_le, b_fe});
    end
    drive(1'b0, 1'b0);
    drive(1'b1, 1'b0);
    drive(1'b1, 1'b0);
  endtask

  // First tick after release arrives on the CLK_DIV-th enabled clock.
  task automatic test_release();
    for (int i = 0; i < DA; i++) begin
      en    = 1'b1;
      reset = 1'b1;
      #2;
      checks++;
      if (a_pt !== (i == DA - 1)) begin
        errors++;
        $display("FAIL release_tick clk %0d: got %b, want %b", i, a_pt, (i == DA - 1));
      end
      drive(1'b1, 1'b1);
    end
  endtask

  task automatic test_full_frame();
    int a_le_n = 0, a_fe_n = 0, a_hs_n = 0, a_vo_n = 0, a_vs_n = 0;
    int b_le_n = 0, b_fe_n = 0, b_hs_n = 0;
    for (int i = 0; i < HT * VT * DA; i++) begin
      en    = 1'b1;
      reset = 1'b1;
      #2;
      a_le_n += int'(a_le);
      a_fe_n += int'(a_fe);
      a_hs_n += int'(!a_hs);
      a_vs_n += int'(!a_vs);
      a_vo_n += int'(a_vo);
      b_le_n += int'(b_le);
      b_fe_n += int'(b_fe);
      b_hs_n += int'(b_hs);
      drive(1'b1, 1'b1);
    end
    checks++;
    if (a_le_n != VT || a_fe_n != 1) begin
      errors++;
      $display("FAIL frame_a_strobes: got le=%0d fe=%0d, want %0d 1", a_le_n, a_fe_n, VT);
    end
    checks++;
    if (a_hs_n != HS * VT * DA || a_vs_n != VS * HT * DA) begin
      errors++;
      $display("FAIL frame_a_sync: got hs=%0d vs=%0d clks, want %0d %0d",
               a_hs_n, a_vs_n, HS * VT * DA, VS * HT * DA);
    end
    checks++;
    if (a_vo_n != HA * VA * DA) begin
      errors++;
      $display("FAIL frame_a_video: got %0d clks, want %0d", a_vo_n, HA * VA * DA);
    end
    checks++;
    if (b_le_n != VT * DA || b_fe_n != DA || b_hs_n != HS * VT * DA) begin
      errors++;
      $display("FAIL frame_b: got le=%0d fe=%0d hs=%0d, want %0d %0d %0d",
               b_le_n, b_fe_n, b_hs_n, VT * DA, DA, HS * VT * DA);
    end
  endtask

  task automatic test_enable_hold();
    int   n = 0;
    st_t  hold_b;
    while (!(sa.x == 5 && sa.div == 1) && n < 2000) begin
      drive(1'b1, 1'b1);
      n++;
    end
    checks++;
    if (n >= 2000) begin
      errors++;
      $display("FAIL hold_setup: got no x=5 within %0d clks, want x=5 div=1", n);
    end
    hold_b = sb;
    for (int i = 0; i < 7; i++) begin
      drive(1'b0, 1'b1);
      checks++;
      if (a_x !== 10'd5 || dut_a.r_div !== 8'd1 || b_x !== 10'(hold_b.x)) begin
        errors++;
        $display("FAIL hold_frozen clk %0d: got a_x=%0d div=%0d b_x=%0d, want 5 1 %0d",
                 i, a_x, dut_a.r_div, b_x, hold_b.x);
      end
    end
    for (int i = 0; i < 8; i++) drive(1'b1, 1'b1);
  endtask

  task automatic test_mid_reset();
    int n = 0;
    while (!(sa.x == HA + HF && sa.y == VA + VF) && n < 2000) begin
      drive(1'b1, 1'b1);
      n++;
    end
    checks++;
    if (n >= 2000 || a_hs !== 1'b0 || a_vs !== 1'b0) begin
      errors++;
      $display("FAIL midreset_setup: got hs=%b vs=%b after %0d clks, want 0 0",
               a_hs, a_vs, n);
    end
    reset = 1'b0;
    #1;
    checks++;
    if ({a_x, a_y} !== 20'd0 || {a_hs, a_vs} !== 2'b11 || {b_hs, b_vs} !== 2'b00) begin
      errors++;
      $display("FAIL midreset_async: got x=%0d y=%0d ahs,avs=%b bhs,bvs=%b, want 0 0 11 00",
               a_x, a_y, {a_hs, a_vs}, {b_hs, b_vs});
    end
    drive(1'b1, 1'b0);
    drive(1'b1, 1'b0);
    test_release();
  endtask

  task automatic test_random_en();
    for (int i = 0; i < 300; i++) drive(1'($urandom_range(0, 1)), 1'b1);
  endtask

`ifdef VGA_TIMING_FRAME_CNT_EN
  task automatic test_frame_cnt();
    drive(1'b1, 1'b0);
    for (int i = 0; i < 3 * HT * VT; i++) drive(1'b1, 1'b1);
    checks++;
    if (b_fc !== 16'd3) begin
      errors++;
      $display("FAIL frame_cnt_3: got %0d, want 3", b_fc);
    end
    force dut_b.r_frame_cnt = 16'hFFFF;
    #1;
    release dut_b.r_frame_cnt;
    for (int i = 0; i < HT * VT; i++) drive(1'b1, 1'b1);
    checks++;
    if (b_fc !== 16'd0) begin
      errors++;
      $display("FAIL frame_cnt_wrap: got %0d, want 0", b_fc);
    end
  endtask
`endif

  initial begin
    sa = '{0, 0, 0};
    sb = '{0, 0, 0};
    @(posedge clk);
    #1;
    test_reset();
    test_release();
    test_full_frame();
    test_enable_hold();
    test_mid_reset();
    test_random_en();
`ifdef VGA_TIMING_FRAME_CNT_EN
    test_frame_cnt();
`endif
    drive(1'b0, 1'b1);
    @(posedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
